dmem_arbiter: RTL and testbench

Two-master arbiter sharing the single-port data RAM between the core load/store unit (port C) and the debug/loader port (port D). Core has priority by default; a starvation counter forces a debug grant after a bounded wait. Per-request responses are routed back with fixed one-cycle latency. Out-of-range accesses are terminated locally with an error. Sits between core/debug request buses and the data RAM instance.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_prio.sv | 56 +++++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: master indices and response record.
package dmem_arb_pkg;

  localparam int unsigned MST_C   = 0;
  localparam int unsigned MST_D   = 1;
  localparam int unsigned NUM_MST = 2;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   we;
    logic   err;
  } rsp_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant decision for the core (C) and debug (D) masters with a starvation
// counter that forces a debug grant after STARVE_LIMIT consecutive waits.
module dmem_arb_prio
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic c_req,
  input  logic d_req,
  output logic c_gnt,
  output logic d_gnt
);

  localparam int unsigned      CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]    LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]      starve_cnt_q, starve_cnt_d;
  logic               forced;
  logic [NUM_MST-1:0] gnt;

  // Priority C > D unless D has waited STARVE_LIMIT cycles; no grant while in reset.
  always_comb begin
    gnt    = '0;
    forced = (starve_cnt_q == LIMIT);
    if (!rst) begin
      if (d_req && (forced || !c_req)) begin
        gnt[MST_D] = 1'b1;
      end else if (c_req) begin
        gnt[MST_C] = 1'b1;
      end
    end
  end

  // Count consecutive waiting cycles of D, saturating at the limit.
  always_comb begin
    starve_cnt_d = '0;
    if (d_req && !gnt[MST_D]) begin
      starve_cnt_d = forced ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign c_gnt = gnt[MST_C];
  assign d_gnt = gnt[MST_D];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data RAM: range check,
// RAM request mux and one-cycle response routing back to the winner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned MEM_BYTES    = 16384,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             c_req,
  input  logic                             c_we,
  input  logic [3:0]                       c_be,
  input  logic [ADDR_W-1:0]                c_addr,
  input  logic [31:0]                      c_wdata,
  output logic                             c_gnt,
  output logic                             c_rvalid,
  output logic [31:0]                      c_rdata,
  output logic                             c_err,
  input  logic                             d_req,
  input  logic                             d_we,
  input  logic [3:0]                       d_be,
  input  logic [ADDR_W-1:0]                d_addr,
  input  logic [31:0]                      d_wdata,
  output logic                             d_gnt,
  output logic                             d_rvalid,
  output logic [31:0]                      d_rdata,
  output logic                             d_err,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [3:0]                       ram_be,
  output logic [$clog2(MEM_BYTES)-3:0]     ram_addr,
  output logic [31:0]                      ram_wdata,
  input  logic [31:0]                      ram_rdata
);

  localparam int unsigned       AW      = $clog2(MEM_BYTES);
  localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);

  logic c_in_range, d_in_range;
  logic win_ok;
  rsp_t rsp_q, rsp_d;

  dmem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk  (clk),
    .rst  (rst),
    .c_req(c_req),
    .d_req(d_req),
    .c_gnt(c_gnt),
    .d_gnt(d_gnt)
  );

  // Per-port range check; full address compared so wide addresses wrap to error, not alias.
  always_comb begin
    c_in_range = ({1'b0, c_addr} < MEM_LIM);
    d_in_range = ({1'b0, d_addr} < MEM_LIM);
  end

  // Steer the winner onto the RAM bus; out-of-range grants leave the bus idle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    win_ok    = 1'b0;
    rsp_d     = '0;
    if (d_gnt) begin
      win_ok = d_in_range;
      rsp_d  = '{valid: 1'b1, owner: OWN_D, we: d_we, err: !d_in_range};
      if (d_in_range) begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        ram_be    = d_be;
        ram_addr  = d_addr[AW-1:2];
        ram_wdata = d_wdata;
      end
    end else if (c_gnt) begin
      win_ok = c_in_range;
      rsp_d  = '{valid: 1'b1, owner: OWN_C, we: c_we, err: !c_in_range};
      if (c_in_range) begin
        ram_en    = 1'b1;
        ram_we    = c_we;
        ram_be    = c_be;
        ram_addr  = c_addr[AW-1:2];
        ram_wdata = c_wdata;
      end
    end
    if (!win_ok) begin
      ram_en = 1'b0;
    end
  end

  // Response tracker; reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Route the response to its owner; data only for successful loads.
  always_comb begin
    c_rvalid = rsp_q.valid && (rsp_q.owner == OWN_C);
    d_rvalid = rsp_q.valid && (rsp_q.owner == OWN_D);
    c_err    = c_rvalid && rsp_q.err;
    d_err    = d_rvalid && rsp_q.err;
    c_rdata  = (c_rvalid && !rsp_q.we && !rsp_q.err) ? ram_rdata : '0;
    d_rdata  = (d_rvalid && !rsp_q.we && !rsp_q.err) ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural RAM model.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned MEM_BYTES = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, d_req, d_we;
  logic [3:0]  c_be, d_be;
  logic [31:0] c_addr, d_addr, c_wdata, d_wdata;
  logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] mem [0:4095];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .MEM_BYTES   (MEM_BYTES),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Read-first synchronous RAM with byte enables.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
      end
    end
  end

  task automatic drive_c(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    c_req = req; c_we = we; c_be = be; c_addr = addr; c_wdata = wdata;
  endtask

  task automatic drive_d(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    d_req = req; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic test_reset;
    @(negedge clk);
    drive_c(1'b1, 1'b0, 4'hF, 32'h4, '0);
    drive_d(1'b1, 1'b1, 4'hF, 32'h8, 32'h5555_5555);
    #1;
    tests++; if ({c_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b want 00", {c_gnt, d_gnt}); end
    tests++; if ({ram_en, ram_we, ram_be, ram_addr, ram_wdata} !== '0) begin fails++; $display("FAIL rst_ram: en=%b we=%b be=%h addr=%h wdata=%h want all 0", ram_en, ram_we, ram_be, ram_addr, ram_wdata); end
    tests++; if ({c_rvalid, c_err, d_rvalid, d_err, c_rdata, d_rdata} !== '0) begin fails++; $display("FAIL rst_rsp: c_rvalid=%b d_rvalid=%b c_rdata=%h d_rdata=%h want 0", c_rvalid, d_rvalid, c_rdata, d_rdata); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    drive_d(1'b0, 1'b0, 4'h0, '0, '0);
    rst = 1'b0;
    #1;
    tests++; if ({c_rvalid, d_rvalid} !== 2'b00) begin fails++; $display("FAIL rst_release_rvalid: got %b want 00", {c_rvalid, d_rvalid}); end
  endtask

  task automatic test_core_load;
    @(negedge clk);
    drive_c(1'b1, 1'b0, 4'hF, 32'h4, '0);
    #1;
    tests++; if ({c_gnt, d_gnt} !== 2'b10) begin fails++; $display("FAIL load_gnt: got %b want 10", {c_gnt, d_gnt}); end
    tests++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 12'h001}) begin fails++; $display("FAIL load_ram: en=%b we=%b addr=%h want 1 0 001", ram_en, ram_we, ram_addr); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({c_rvalid, c_err, d_rvalid} !== 3'b100) begin fails++; $display("FAIL load_rvalid: c_rvalid,c_err,d_rvalid=%b want 100", {c_rvalid, c_err, d_rvalid}); end
    tests++; if (c_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL load_rdata: got %h want deadbeef", c_rdata); end
    @(negedge clk);
    #1;
    tests++; if (c_rvalid !== 1'b0) begin fails++; $display("FAIL load_single_rsp: c_rvalid=%b want 0", c_rvalid); end
  endtask

  task automatic test_core_store;
    @(negedge clk);
    drive_c(1'b1, 1'b1, 4'b0011, 32'h8, 32'h1234_5678);
    #1;
    tests++; if ({c_gnt, ram_en, ram_we, ram_be, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 4'b0011, 12'h002, 32'h1234_5678}) begin
      fails++; $display("FAIL store_ram: gnt=%b en=%b we=%b be=%b addr=%h wdata=%h want 1 1 1 0011 002 12345678", c_gnt, ram_en, ram_we, ram_be, ram_addr, ram_wdata); end
    @(negedge clk);
    drive_c(1'b1, 1'b0, 4'hF, 32'h8, '0);
    #1;
    tests++; if ({c_rvalid, c_err, c_rdata} !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("FAIL store_rsp: rvalid=%b err=%b rdata=%h want 1 0 00000000", c_rvalid, c_err, c_rdata); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({c_rvalid, c_rdata} !== {1'b1, 32'hAAAA_5678}) begin fails++; $display("FAIL store_reload: rvalid=%b rdata=%h want 1 aaaa5678", c_rvalid, c_rdata); end
  endtask

  // Both masters request every cycle for n cycles; D expected on every 5th grant.
  task automatic run_contention(input string tag, input int n);
    logic prev_c, prev_d, exp_c, exp_d;
    prev_c = 1'b0; prev_d = 1'b0;
    drive_c(1'b1, 1'b0, 4'hF, 32'h4, '0);
    drive_d(1'b1, 1'b0, 4'hF, 32'h8, '0);
    for (int i = 0; i < n; i++) begin
      exp_d = ((i % 5) == 4);
      exp_c = !exp_d;
      #1;
      tests++; if ({c_gnt, d_gnt} !== {exp_c, exp_d}) begin fails++; $display("FAIL %s_gnt[%0d]: got %b want %b", tag, i, {c_gnt, d_gnt}, {exp_c, exp_d}); end
      tests++; if ({c_rvalid, d_rvalid} !== {prev_c, prev_d}) begin fails++; $display("FAIL %s_rvalid[%0d]: got %b want %b", tag, i, {c_rvalid, d_rvalid}, {prev_c, prev_d}); end
      if (prev_d) begin
        tests++; if (d_rdata !== 32'hAAAA_5678) begin fails++; $display("FAIL %s_drdata[%0d]: got %h want aaaa5678", tag, i, d_rdata); end
      end
      prev_c = exp_c; prev_d = exp_d;
      @(negedge clk);
    end
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    drive_d(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({c_rvalid, d_rvalid} !== {prev_c, prev_d}) begin fails++; $display("FAIL %s_last_rvalid: got %b want %b", tag, {c_rvalid, d_rvalid}, {prev_c, prev_d}); end
  endtask

  task automatic test_starvation;
    @(negedge clk);
    run_contention("starve", 10);
  endtask

  task automatic test_back_to_back_same_addr;
    @(negedge clk);
    drive_c(1'b1, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D);
    drive_d(1'b1, 1'b0, 4'hF, 32'h10, '0);
    #1;
    tests++; if ({c_gnt, d_gnt} !== 2'b10) begin fails++; $display("FAIL same_first_gnt: got %b want 10", {c_gnt, d_gnt}); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({d_gnt, c_rvalid, d_rvalid} !== 3'b110) begin fails++; $display("FAIL same_second: d_gnt,c_rvalid,d_rvalid=%b want 110", {d_gnt, c_rvalid, d_rvalid}); end
    @(negedge clk);
    drive_d(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({d_rvalid, d_err, d_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin fails++; $display("FAIL same_dload: rvalid=%b err=%b rdata=%h want 1 0 cafef00d", d_rvalid, d_err, d_rdata); end
  endtask

  task automatic test_out_of_range;
    @(negedge clk);
    drive_d(1'b1, 1'b0, 4'hF, MEM_BYTES, '0);
    #1;
    tests++; if ({d_gnt, ram_en, ram_addr} !== {1'b1, 1'b0, 12'h000}) begin fails++; $display("FAIL oob_ram: gnt=%b en=%b addr=%h want 1 0 000", d_gnt, ram_en, ram_addr); end
    @(negedge clk);
    drive_d(1'b0, 1'b0, 4'h0, '0, '0);
    drive_c(1'b1, 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0BAD_0BAD);
    #1;
    tests++; if ({d_rvalid, d_err, d_rdata, c_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin fails++; $display("FAIL oob_rsp: d_rvalid=%b d_err=%b d_rdata=%h c_rvalid=%b want 1 1 0 0", d_rvalid, d_err, d_rdata, c_rvalid); end
    tests++; if ({c_gnt, ram_en, ram_we} !== 3'b100) begin fails++; $display("FAIL oob_store_ram: gnt=%b en=%b we=%b want 1 0 0", c_gnt, ram_en, ram_we); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({c_rvalid, c_err, d_rvalid, d_err} !== 4'b1100) begin fails++; $display("FAIL oob_store_rsp: c_rvalid,c_err,d_rvalid,d_err=%b want 1100", {c_rvalid, c_err, d_rvalid, d_err}); end
  endtask

  task automatic test_zero_be;
    @(negedge clk);
    drive_c(1'b1, 1'b0, 4'h0, 32'h7, '0);
    #1;
    tests++; if ({c_gnt, ram_en, ram_be, ram_addr} !== {1'b1, 1'b1, 4'h0, 12'h001}) begin fails++; $display("FAIL zbe_ram: gnt=%b en=%b be=%b addr=%h want 1 1 0000 001", c_gnt, ram_en, ram_be, ram_addr); end
    @(negedge clk);
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    #1;
    tests++; if ({c_rvalid, c_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL zbe_rdata: rvalid=%b rdata=%h want 1 deadbeef", c_rvalid, c_rdata); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive_c(1'b1, 1'b0, 4'hF, 32'h4, '0);
    drive_d(1'b1, 1'b0, 4'hF, 32'h8, '0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    tests++; if ({c_rvalid, d_rvalid, c_gnt, d_gnt, ram_en} !== 5'b00000) begin fails++; $display("FAIL rstmid_hold: c_rvalid,d_rvalid,c_gnt,d_gnt,ram_en=%b want 00000", {c_rvalid, d_rvalid, c_gnt, d_gnt, ram_en}); end
    rst = 1'b0;
    run_contention("postrst", 5);
  endtask

  initial begin
    rst = 1'b1;
    drive_c(1'b0, 1'b0, 4'h0, '0, '0);
    drive_d(1'b0, 1'b0, 4'h0, '0, '0);
    for (int w = 0; w < 4096; w++) mem[w] = '0;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'hAAAA_AAAA;
    mem[4] = 32'h1111_1111;
    test_reset;
    test_core_load;
    test_core_store;
    test_starvation;
    test_back_to_back_same_addr;
    test_out_of_range;
    test_zero_be;
    test_reset_mid;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
